// File: rtl/sram_responder.sv
// Behavioural stand-in for a 16-bit asynchronous SRAM chip, answering the controller pin protocol.
// Optional protocol checker is compiled in with `define SRAM_RESP_CHECK_EN; otherwise err is tied low.
module sram_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_DRV} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);
  // With a one-clock latency the read parks in RD_DRV with the driver off for one
  // edge, so the first drive still lands RD_LAT edges after the request.
  localparam state_t RD_START = (RD_LAT == 1) ? RD_DRV : RD_WAIT;

  state_t            state, state_nx;
  logic [3:0]        lat_cnt, lat_cnt_nx;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
  logic              dq_oe, dq_oe_nx;
  logic              start_rd;

  logic [15:0]       mem [2**ADDR_W];
  logic [15:0]       rd_data;
  logic [ADDR_W-1:0] addr_lo;
  logic              wr_req, rd_req, same_addr, dq_drive;

  assign wr_req    = ~SRAM_CE_N & ~SRAM_WE_N;
  assign rd_req    = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;
  assign addr_lo   = SRAM_ADDR[ADDR_W-1:0];
  assign same_addr = (addr_lo == rd_addr);
  assign rd_data   = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      rd_addr <= '0;
      dq_oe   <= 1'b0;
    end else begin
      state   <= state_nx;
      lat_cnt <= lat_cnt_nx;
      rd_addr <= rd_addr_nx;
      dq_oe   <= dq_oe_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    lat_cnt_nx = lat_cnt;
    rd_addr_nx = rd_addr;
    dq_oe_nx   = 1'b0;
    start_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req)      state_nx = WR;
        else if (rd_req) start_rd = 1'b1;
      end
      WR: begin
        // A read arriving straight after a write starts immediately so that
        // back-to-back traffic keeps the nominal read latency.
        if (wr_req)      state_nx = WR;
        else if (rd_req) start_rd = 1'b1;
        else             state_nx = IDLE;
      end
      RD_WAIT: begin
        if (wr_req)              state_nx = WR;
        else if (!rd_req)        state_nx = IDLE;
        else if (!same_addr)     start_rd = 1'b1;
        else if (lat_cnt == '0) begin
          state_nx = RD_DRV;
          dq_oe_nx = 1'b1;
        end else                 lat_cnt_nx = lat_cnt - 4'd1;
      end
      RD_DRV: begin
        if (wr_req)          state_nx = WR;
        else if (!rd_req)    state_nx = IDLE;
        else if (!same_addr) start_rd = 1'b1;
        else                 dq_oe_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (start_rd) begin
      rd_addr_nx = addr_lo;
      lat_cnt_nx = LAT_LOAD;
      state_nx   = RD_START;
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    dq_drive = dq_oe & SRAM_WE_N & ~SRAM_CE_N;
  end

  assign SRAM_DQ = dq_drive ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (!rst && wr_req) begin
      if (!SRAM_UB_N) mem[addr_lo][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[addr_lo][7:0]  <= SRAM_DQ[7:0];
    end
  end

`ifdef SRAM_RESP_CHECK_EN
  logic [17:0] wr_addr_q;
  logic        err_q;
  logic        viol;

  assign viol = (~SRAM_CE_N & ~SRAM_WE_N & ~SRAM_OE_N)
              | ((state == WR) & wr_req & (SRAM_ADDR != wr_addr_q))
              | ((wr_req | rd_req) & ((SRAM_ADDR >> ADDR_W) != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      if (wr_req) wr_addr_q <= SRAM_ADDR;
      if (viol)   err_q     <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^(SRAM_ADDR >> ADDR_W);
  assign err = 1'b0;
`endif

endmodule
